// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem store buffer: defaults, FIFO entry layout, word indexing.
package dmem_pkg;

  localparam int unsigned WORD_BYTES         = 4;
  localparam int unsigned SB_DEPTH_DEFAULT   = 4;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 10;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned WORD_IDX_BITS      = 32 - $clog2(WORD_BYTES);

  // Entries keep the full word index so aliasing is decided only at compare time.
  typedef struct packed {
    logic [WORD_IDX_BITS-1:0]      idx;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } sb_entry_t;

  function automatic logic [WORD_IDX_BITS-1:0] word_index(input logic [31:0] addr);
    return addr[31:$clog2(WORD_BYTES)];
  endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// MEM-stage data-memory bus between the core (master) and the store buffer (slave).
interface dmem_store_buffer_if import dmem_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic                  read_en;
  logic                  write_en;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (output read_en, write_en, address, write_data, input read_data);
  modport slave  (input read_en, write_en, address, write_data, output read_data);
endinterface

// File: rtl/dmem_word_ram.sv
// Local word RAM: combinational read, synchronous write, contents unaffected by reset.
module dmem_word_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO in front of dmem_word_ram with youngest-match load forwarding.
// Define DMEM_SB_STATS_EN to add saturating forward-hit / drain-block counters.
module dmem_store_buffer import dmem_pkg::*; #(
  parameter int unsigned DEPTH      = SB_DEPTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_store_buffer_if.slave     bus,
  output logic                   sb_empty_out,
  output logic [$clog2(DEPTH):0] sb_count_out
`ifdef DMEM_SB_STATS_EN
  ,
  output logic [31:0]            fwd_hit_count_out,
  output logic [31:0]            drain_block_count_out
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sb_entry_t             fifo [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W:0]        count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  full;
  logic                  drain;
  logic                  push;
  logic                  hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign idx  = ADDR_WIDTH'(word_index(bus.address));
  assign full = (count == (PTR_W+1)'(DEPTH));
  assign push = bus.write_en;
  // A load owns the RAM port, except a full FIFO must make room for a concurrent store.
  assign drain = (count != '0) && (!bus.read_en || (bus.write_en && full));

  // Walk oldest to youngest so the youngest matching entry is the last to overwrite.
  always_comb begin
    logic [PTR_W-1:0] pos;
    hit      = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (valid[pos] && (fifo[pos].idx[ADDR_WIDTH-1:0] == idx)) begin
        hit      = 1'b1;
        fwd_data = DATA_WIDTH'(fifo[pos].data);
      end
    end
  end

  assign bus.read_data = (rst || !bus.read_en) ? '0 : (hit ? fwd_data : ram_rdata);
  assign sb_empty_out  = (count == '0);
  assign sb_count_out  = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      // On a full drain+push head==tail; this later assignment keeps the slot valid.
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo[tail] <= '{idx: word_index(bus.address), data: DATA_WIDTH_DEFAULT'(bus.write_data)};
    end
  end

  dmem_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (drain),
    .wr_idx  (fifo[head].idx[ADDR_WIDTH-1:0]),
    .wr_data (DATA_WIDTH'(fifo[head].data)),
    .rd_idx  (idx),
    .rd_data (ram_rdata)
  );

`ifdef DMEM_SB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_count_out     <= '0;
      drain_block_count_out <= '0;
    end else begin
      if (bus.read_en && hit && (fwd_hit_count_out != '1))
        fwd_hit_count_out <= fwd_hit_count_out + 32'd1;
      if (bus.read_en && (count != '0) && (drain_block_count_out != '1))
        drain_block_count_out <= drain_block_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed-vector bench for dmem_store_buffer (DEPTH=4, ADDR_WIDTH=10); stats checks under DMEM_SB_STATS_EN.
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_empty_out;
  logic [2:0]  sb_count_out;
`ifdef DMEM_SB_STATS_EN
  logic [31:0] fwd_hits;
  logic [31:0] drain_blocks;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  dmem_store_buffer_if #(.DATA_WIDTH(32)) bus ();

  dmem_store_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus),
    .sb_empty_out          (sb_empty_out),
    .sb_count_out          (sb_count_out)
`ifdef DMEM_SB_STATS_EN
    ,
    .fwd_hit_count_out     (fwd_hits),
    .drain_block_count_out (drain_blocks)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.read_en    = re;
    bus.write_en   = we;
    bus.address    = a;
    bus.write_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick();
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    chk(tag, bus.read_data, exp);
    tick();
  endtask

  task automatic cnt(input string tag, input logic [31:0] exp);
    chk(tag, 32'(sb_count_out), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    chk("rst_read_zero", bus.read_data, 32'h0);
    tick();
    tick();
    cnt("rst_count", 0);
    chk("rst_empty", 32'(sb_empty_out), 1);
    rst = 1'b0;

    // 1: store, two idle cycles, load from RAM
    st(32'h100, 32'hDEAD_BEEF);
    cnt("t1_count_after_store", 1);
    chk("t1_not_empty", 32'(sb_empty_out), 0);
    drive(1'b0, 1'b0, 32'h100, 32'h0);
    chk("t1_read_en0_zero", bus.read_data, 32'h0);
    tick();
    cnt("t1_count_after_drain", 0);
    idle();
    ld("t1_load_ram", 32'h100, 32'hDEAD_BEEF);

    // 2: two stores to one word, youngest wins
    st(32'h40, 32'h1);
    drive(1'b1, 1'b1, 32'h40, 32'h2);
    chk("t2_rw_pre_edge_fwd", bus.read_data, 32'h1);
    tick();
    cnt("t2_count_two", 2);
    ld("t2_youngest_fwd", 32'h40, 32'h2);
    cnt("t2_load_blocks_drain", 2);
    idle();
    idle();
    cnt("t2_drained", 0);
    ld("t2_ram_final", 32'h40, 32'h2);

    // 3: loads starve the drain
    rw(32'h200, 32'hA);
    rw(32'h204, 32'hB);
    rw(32'h208, 32'hC);
    cnt("t3_count_three", 3);
    for (int i = 0; i < 6; i++) ld($sformatf("t3_load_%0d", i), 32'h100, 32'hDEAD_BEEF);
    cnt("t3_count_held", 3);
    idle();
    cnt("t3_first_idle", 2);
    idle();
    idle();
    cnt("t3_empty", 0);
    ld("t3_ram_a", 32'h200, 32'hA);
    ld("t3_ram_b", 32'h204, 32'hB);
    ld("t3_ram_c", 32'h208, 32'hC);

    // 4: DEPTH+3 plain stores drain one-for-one
    for (int i = 0; i < DEPTH + 3; i++) begin
      st(32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
      cnt($sformatf("t4_count_%0d", i), 1);
    end
    idle();
    cnt("t4_empty", 0);
    for (int i = 0; i < DEPTH + 3; i++)
      ld($sformatf("t4_read_%0d", i), 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));

    // full FIFO with concurrent load+store force-drains the head
    for (int i = 0; i < DEPTH + 1; i++) begin
      rw(32'h500 + 32'(4 * i), 32'h2000 + 32'(i));
      cnt($sformatf("full_count_%0d", i), (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) idle();
    cnt("full_drained", 0);
    for (int i = 0; i < DEPTH + 1; i++)
      ld($sformatf("full_read_%0d", i), 32'h500 + 32'(4 * i), 32'h2000 + 32'(i));

    // 5: address aliasing above ADDR_WIDTH
    st(32'h0004, 32'h5555_AAAA);
    ld("t5_alias_fwd", 32'h1004, 32'h5555_AAAA);
    idle();
    ld("t5_alias_ram", 32'h1004, 32'h5555_AAAA);
`ifdef DMEM_SB_STATS_EN
    chk("stats_fwd_hits", fwd_hits, 32'd3);
    chk("stats_drain_blocks", drain_blocks, 32'd15);
`endif

    // 6: reset discards pending stores, RAM keeps drained data
    st(32'h600, 32'h77);
    idle();
    drive(1'b1, 1'b1, 32'h600, 32'h11);
    chk("t6_rw_reads_ram", bus.read_data, 32'h77);
    tick();
    rw(32'h604, 32'h22);
    cnt("t6_pending_two", 2);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h600, 32'h0);
    chk("t6_rst_read_zero", bus.read_data, 32'h0);
    tick();
    rst = 1'b0;
    chk("t6_empty", 32'(sb_empty_out), 1);
    cnt("t6_count_zero", 0);
`ifdef DMEM_SB_STATS_EN
    chk("t6_fwd_cleared", fwd_hits, 32'd0);
    chk("t6_block_cleared", drain_blocks, 32'd0);
`endif
    ld("t6_old_ram", 32'h600, 32'h77);
    idle();
    cnt("t6_still_empty", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
